// File: rtl/csr_interrupt_ctrl.sv
// csr_interrupt_ctrl: machine-mode timer interrupt controller and trap CSR file with mret redirect.
// Define VECTORED_MTVEC_EN to enable mtvec vectored mode (mode 2'b01, target base + 0x1C).
module csr_interrupt_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            timer_interrupt,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_in,
  input  logic            is_mret,
  input  logic            csr_wr,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            intr_taken
);
  typedef enum logic {IDLE, REDIRECT} state_t;
  localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
`ifdef VECTORED_MTVEC_EN
  localparam logic [1:0] RST_MODE = (MTVEC_RESET[1:0] == 2'b01) ? 2'b01 : 2'b00;
`else
  localparam logic [1:0] RST_MODE = 2'b00;
`endif
  state_t state_q, state_d;
  logic mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d, mtip_q, mtip_d, intr_q, intr_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtvec_q, mtvec_d, rpc_q, rpc_d;
  logic idle, take, ret, wr;
  logic [1:0] wmode;
  logic [XLEN-1:0] base, tvec;
  assign idle = state_q == IDLE;
  assign take = idle & mie_q & mtie_q & mtip_q & instr_valid & ~is_mret;
  assign ret  = idle & is_mret & instr_valid;
  // A trap replays its instruction, so its CSR write is dropped; nothing is written while flushing.
  assign wr   = idle & csr_wr & ~take;
  assign base = mtvec_q & ALIGN;
`ifdef VECTORED_MTVEC_EN
  assign wmode = (csr_wdata[1:0] == 2'b01) ? 2'b01 : 2'b00;
  assign tvec  = (mtvec_q[1:0] == 2'b01) ? base + XLEN'(28) : base;
`else
  assign wmode = 2'b00;
  assign tvec  = base;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb state_d = (idle && (take || ret)) ? REDIRECT : IDLE;
  always_comb begin
    redirect_valid = state_q == REDIRECT;
    intr_taken     = (state_q == REDIRECT) & intr_q;
    redirect_pc    = (state_q == REDIRECT) ? rpc_q : '0;
  end
  always_comb begin
    mie_d    = take ? 1'b0 : ret ? mpie_q : (wr && csr_addr == 12'h300) ? csr_wdata[3] : mie_q;
    mpie_d   = take ? mie_q : ret ? 1'b1 : (wr && csr_addr == 12'h300) ? csr_wdata[7] : mpie_q;
    mtie_d   = (wr && csr_addr == 12'h304) ? csr_wdata[7] : mtie_q;
    mtip_d   = timer_interrupt | (mtip_q & ~take);
    mepc_d   = take ? pc_in & ALIGN : (wr && csr_addr == 12'h341) ? csr_wdata & ALIGN : mepc_q;
    mcause_d = take ? CAUSE_MTI : (wr && csr_addr == 12'h342) ? csr_wdata : mcause_q;
    mtvec_d  = (wr && csr_addr == 12'h305) ? {csr_wdata[XLEN-1:2], wmode} : mtvec_q;
    rpc_d    = take ? tvec : ret ? mepc_q : rpc_q;
    intr_d   = take;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtie_q   <= 1'b0;
      mtip_q   <= 1'b0;
      intr_q   <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
      mtvec_q  <= {MTVEC_RESET[XLEN-1:2], RST_MODE};
      rpc_q    <= '0;
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtie_q   <= mtie_d;
      mtip_q   <= mtip_d;
      intr_q   <= intr_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
      mtvec_q  <= mtvec_d;
      rpc_q    <= rpc_d;
    end
  always_comb begin
    csr_rdata = '0;
    case (csr_addr)
      12'h300: csr_rdata = {{(XLEN-8){1'b0}}, mpie_q, 3'b000, mie_q, 3'b000};
      12'h304: csr_rdata = {{(XLEN-8){1'b0}}, mtie_q, 7'b0};
      12'h305: csr_rdata = mtvec_q;
      12'h341: csr_rdata = mepc_q;
      12'h342: csr_rdata = mcause_q;
      12'h344: csr_rdata = {{(XLEN-8){1'b0}}, mtip_q, 7'b0};
      default: csr_rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_csr_interrupt_ctrl.sv
// tb_csr_interrupt_ctrl: table-driven per-cycle vectors plus an async-reset-mid-redirect sequence.
module tb_csr_interrupt_ctrl;
  logic clk = 0, rst = 1;
  logic timer_interrupt = 0, instr_valid = 0, is_mret = 0, csr_wr = 0;
  logic [31:0] pc_in = 0, csr_wdata = 0, csr_rdata, redirect_pc;
  logic [11:0] csr_addr = 0;
  logic redirect_valid, intr_taken;
  int n_tests = 0, n_fail = 0;
`ifdef VECTORED_MTVEC_EN
  localparam logic [31:0] MTV_RD = 32'h201, MTV_TGT = 32'h21C;
`else
  localparam logic [31:0] MTV_RD = 32'h200, MTV_TGT = 32'h200;
`endif
  typedef struct {
    logic tmr, iv, mret, wr;
    logic [31:0] pc;
    logic [11:0] a;
    logic [31:0] wd;
    logic rv, it;
    logic [31:0] rpc, rd;
  } vec_t;
  vec_t v[$];

  csr_interrupt_ctrl dut (
    .clk(clk), .rst(rst), .timer_interrupt(timer_interrupt), .instr_valid(instr_valid),
    .pc_in(pc_in), .is_mret(is_mret), .csr_wr(csr_wr), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .intr_taken(intr_taken)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic tmr, iv, mret, wr, input logic [31:0] pc, input logic [11:0] a,
                     input logic [31:0] wd, input logic rv, it, input logic [31:0] rpc, rd);
    vec_t e;
    e.tmr = tmr; e.iv = iv; e.mret = mret; e.wr = wr; e.pc = pc; e.a = a; e.wd = wd;
    e.rv = rv; e.it = it; e.rpc = rpc; e.rd = rd;
    v.push_back(e);
  endtask

  task automatic step(input vec_t e, input int idx);
    timer_interrupt = e.tmr; instr_valid = e.iv; is_mret = e.mret; csr_wr = e.wr;
    pc_in = e.pc; csr_addr = e.a; csr_wdata = e.wd;
    @(posedge clk);
    #1;
    chk("redirect_valid", idx, {31'b0, redirect_valid}, {31'b0, e.rv});
    chk("intr_taken", idx, {31'b0, intr_taken}, {31'b0, e.it});
    chk("redirect_pc", idx, redirect_pc, e.rpc);
    chk("csr_rdata", idx, csr_rdata, e.rd);
  endtask

  task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input int idx);
    csr_addr = a;
    #1;
    chk("csr_read", idx, csr_rdata, exp);
  endtask

  initial begin
    vec_t h;
    //  tmr iv mret wr  pc      addr     wdata          rv it rpc      rdata
    add(0, 0, 0, 1, 32'h0,  12'h305, 32'h100,        0, 0, 32'h0,   32'h100);
    add(0, 0, 0, 1, 32'h0,  12'h304, 32'h80,         0, 0, 32'h0,   32'h80);
    add(0, 0, 0, 1, 32'h0,  12'h300, 32'h8,          0, 0, 32'h0,   32'h8);
    add(1, 1, 0, 0, 32'h40, 12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 0, 32'h40, 12'h341, 32'h0,          1, 1, 32'h100, 32'h40);
    add(0, 0, 0, 0, 32'h0,  12'h342, 32'h0,          0, 0, 32'h0,   32'h8000_0007);
    add(0, 0, 0, 0, 32'h0,  12'h300, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 0, 0, 0, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h0);
    add(0, 1, 1, 0, 32'h50, 12'h300, 32'h0,          1, 0, 32'h40,  32'h88);
    add(0, 0, 0, 0, 32'h0,  12'h300, 32'h0,          0, 0, 32'h0,   32'h88);
    add(0, 0, 0, 1, 32'h0,  12'h304, 32'h0,          0, 0, 32'h0,   32'h0);
    add(1, 0, 0, 0, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 0, 32'h80, 12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 0, 32'h80, 12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 1, 32'h80, 12'h304, 32'h80,         0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 0, 32'h84, 12'h341, 32'h0,          1, 1, 32'h100, 32'h84);
    add(1, 0, 0, 0, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 0, 32'h90, 12'h300, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 1, 0, 32'h94, 12'h300, 32'h0,          1, 0, 32'h84,  32'h88);
    add(0, 1, 0, 0, 32'hA0, 12'h341, 32'h0,          0, 0, 32'h0,   32'h84);
    add(0, 1, 0, 0, 32'hA4, 12'h341, 32'h0,          1, 1, 32'h100, 32'hA4);
    add(0, 0, 0, 0, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h0);
    add(0, 1, 1, 0, 32'hB0, 12'h300, 32'h0,          1, 0, 32'hA4,  32'h88);
    add(1, 0, 0, 0, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 1, 0, 1, 32'hC0, 12'h341, 32'h1234,       1, 1, 32'h100, 32'hC0);
    add(0, 0, 0, 0, 32'h0,  12'h341, 32'h0,          0, 0, 32'h0,   32'hC0);
    add(0, 1, 1, 0, 32'hC4, 12'h300, 32'h0,          1, 0, 32'hC0,  32'h88);
    add(1, 0, 0, 0, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 0, 0, 1, 32'h0,  12'h300, 32'h0,          0, 0, 32'h0,   32'h0);
    add(0, 1, 0, 0, 32'hD0, 12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 0, 0, 1, 32'h0,  12'h344, 32'h0,          0, 0, 32'h0,   32'h80);
    add(0, 0, 0, 1, 32'h0,  12'h123, 32'hFFFF_FFFF,  0, 0, 32'h0,   32'h0);
    add(0, 0, 0, 1, 32'h0,  12'h305, 32'h201,        0, 0, 32'h0,   MTV_RD);
    add(0, 0, 0, 1, 32'h0,  12'h300, 32'h8,          0, 0, 32'h0,   32'h8);
    add(0, 1, 0, 0, 32'hE0, 12'h342, 32'h0,          1, 1, MTV_TGT, 32'h8000_0007);
    add(0, 0, 0, 0, 32'h0,  12'h341, 32'h0,          0, 0, 32'h0,   32'hE0);
    add(0, 0, 0, 1, 32'h0,  12'h305, 32'h303,        0, 0, 32'h0,   32'h300);
    add(0, 0, 0, 1, 32'h0,  12'h341, 32'h1237,       0, 0, 32'h0,   32'h1234);
    add(0, 0, 0, 1, 32'h0,  12'h342, 32'hDEAD_BEEF,  0, 0, 32'h0,   32'hDEAD_BEEF);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_redirect_valid", -1, {31'b0, redirect_valid}, 32'h0);
    chk("rst_intr_taken", -1, {31'b0, intr_taken}, 32'h0);
    chk("rst_redirect_pc", -1, redirect_pc, 32'h0);
    rd_chk(12'h300, 32'h0, -1);
    rd_chk(12'h304, 32'h0, -1);
    rd_chk(12'h305, 32'h0, -1);
    rd_chk(12'h341, 32'h0, -1);
    rd_chk(12'h342, 32'h0, -1);
    rd_chk(12'h344, 32'h0, -1);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < v.size(); i++) step(v[i], i);

    // Trap into mtvec 0x300, then reset asynchronously during the redirect cycle.
    h = '{tmr:1, iv:0, mret:0, wr:1, pc:32'h0, a:12'h300, wd:32'h8, rv:0, it:0, rpc:32'h0, rd:32'h8};
    step(h, 100);
    h = '{tmr:0, iv:1, mret:0, wr:0, pc:32'hF0, a:12'h341, wd:32'h0, rv:1, it:1, rpc:32'h300, rd:32'hF0};
    step(h, 101);
    instr_valid = 0;
    #2 rst = 1;
    #1;
    chk("async_rst_redirect_valid", 102, {31'b0, redirect_valid}, 32'h0);
    chk("async_rst_intr_taken", 102, {31'b0, intr_taken}, 32'h0);
    chk("async_rst_redirect_pc", 102, redirect_pc, 32'h0);
    rd_chk(12'h341, 32'h0, 102);
    rd_chk(12'h305, 32'h0, 102);
    rd_chk(12'h300, 32'h0, 102);
    @(posedge clk);
    #1 rst = 0;
    h = '{tmr:0, iv:1, mret:0, wr:0, pc:32'h10, a:12'h344, wd:32'h0, rv:0, it:0, rpc:32'h0, rd:32'h0};
    step(h, 103);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
